// File: rtl/ecc_apb_regfile_if.sv
// ecc_apb_regfile_if
//   APB3-style bus bundle between a bus master and the ECC register file.
//   Signals:
//     PADDR   [AMBA_ADDR_WIDTH-1:0]  address
//     PSEL                           slave select
//     PENABLE                        access phase qualifier
//     PWRITE                         1 = write, 0 = read
//     PWDATA  [AMBA_WORD-1:0]        write data
//     PRDATA  [AMBA_WORD-1:0]        read data (driven by the slave)
//   Modports: master (drives request, reads PRDATA), slave (the reverse).
interface ecc_apb_regfile_if #(
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32
);
    logic [AMBA_ADDR_WIDTH-1:0] PADDR;
    logic                       PSEL;
    logic                       PENABLE;
    logic                       PWRITE;
    logic [AMBA_WORD-1:0]       PWDATA;
    logic [AMBA_WORD-1:0]       PRDATA;

    modport master (
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  PRDATA
    );

    modport slave (
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output PRDATA
    );
endinterface

// File: rtl/ecc_apb_regfile.sv
// ecc_apb_regfile
//   APB register file and launch sequencer for an ECC core.
//   Register map (PADDR[3:0], upper address bits ignored):
//     0x0 CTRL[1:0]            write launches an operation
//     0x4 DATA_IN              -> core_data_in
//     0x8 CODEWORD_WIDTH[1:0]  -> core_width
//     0xC NOISE                -> core_noise
//   Sequencer: IDLE -> START -> WAIT -> DONE. Register writes are only
//   accepted in IDLE and DONE; reads are always serviced.
//   Ports:
//     clk, rst            clock / asynchronous active-low reset
//     apb                 APB slave (ecc_apb_regfile_if.slave)
//     core_start          one-cycle launch pulse (START state)
//     core_ctrl/width     CTRL and CODEWORD_WIDTH fields
//     core_data_in/noise  DATA_IN and NOISE registers
//     core_done           core result valid
//     core_data_out       core result
//     core_num_errors     core error count
//     data_out            result latched on core_done
//     operation_done      one-cycle completion pulse (DONE state)
//     num_of_errors       error count latched on core_done
//   Build option: ECC_REGFILE_TIMEOUT_EN -- when defined, WAIT gives up
//   after 8 cycles without core_done and reports data_out=0,
//   num_of_errors=2'b11. Undefined, WAIT waits indefinitely.
module ecc_apb_regfile #(
    parameter int DATA_WIDTH      = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    ecc_apb_regfile_if.slave      apb,
    output logic                  core_start,
    output logic [1:0]            core_ctrl,
    output logic [1:0]            core_width,
    output logic [DATA_WIDTH-1:0] core_data_in,
    output logic [DATA_WIDTH-1:0] core_noise,
    input  logic                  core_done,
    input  logic [DATA_WIDTH-1:0] core_data_out,
    input  logic [1:0]            core_num_errors,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  operation_done,
    output logic [1:0]            num_of_errors
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [3:0] ADDR_CTRL  = 4'h0;
    localparam logic [3:0] ADDR_DATA  = 4'h4;
    localparam logic [3:0] ADDR_WIDTH = 4'h8;
    localparam logic [3:0] ADDR_NOISE = 4'hC;

    logic [1:0]            state;
    logic [1:0]            ctrl_r;
    logic [1:0]            width_r;
    logic [DATA_WIDTH-1:0] data_in_r;
    logic [DATA_WIDTH-1:0] noise_r;
    logic [DATA_WIDTH-1:0] data_out_r;
    logic [1:0]            nerr_r;
    logic [AMBA_WORD-1:0]  prdata;

    logic [3:0] reg_addr;
    logic       wr_access;
    logic       rd_access;
    logic       wr_open;
    logic       ctrl_wr;

    // Upper address bits and write-data bits beyond the register widths
    // are deliberately don't-care.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{apb.PADDR, apb.PWDATA};

    assign reg_addr  = apb.PADDR[3:0];
    assign wr_access = apb.PSEL & apb.PENABLE & apb.PWRITE;
    assign rd_access = apb.PSEL & apb.PENABLE & ~apb.PWRITE;
    // Registers are frozen while the core is working on their contents.
    assign wr_open   = (state == ST_IDLE) || (state == ST_DONE);
    assign ctrl_wr   = wr_access && wr_open && (reg_addr == ADDR_CTRL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_r    <= '0;
            width_r   <= '0;
            data_in_r <= '0;
            noise_r   <= '0;
        end else if (wr_access && wr_open) begin
            case (reg_addr)
                ADDR_CTRL:  ctrl_r    <= apb.PWDATA[1:0];
                ADDR_DATA:  data_in_r <= apb.PWDATA[DATA_WIDTH-1:0];
                ADDR_WIDTH: width_r   <= apb.PWDATA[1:0];
                ADDR_NOISE: noise_r   <= apb.PWDATA[DATA_WIDTH-1:0];
                default:    ;
            endcase
        end
    end

`ifdef ECC_REGFILE_TIMEOUT_EN
    // Counts WAIT cycles; cleared everywhere else so each WAIT starts at 0.
    logic [2:0] wait_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (state != ST_WAIT) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 3'd1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            data_out_r <= '0;
            nerr_r     <= '0;
        end else begin
            case (state)
                ST_IDLE:  if (ctrl_wr) state <= ST_START;
                ST_START: state <= ST_WAIT;
                ST_WAIT: begin
                    if (core_done) begin
                        state      <= ST_DONE;
                        data_out_r <= core_data_out;
                        nerr_r     <= core_num_errors;
                    end
`ifdef ECC_REGFILE_TIMEOUT_EN
                    // Eighth WAIT cycle without a result: report failure.
                    else if (wait_cnt == 3'd7) begin
                        state      <= ST_DONE;
                        data_out_r <= '0;
                        nerr_r     <= 2'b11;
                    end
`endif
                end
                // A CTRL write landing in DONE chains straight into a new run.
                ST_DONE:  state <= ctrl_wr ? ST_START : ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        prdata = '0;
        if (rd_access) begin
            case (reg_addr)
                ADDR_CTRL:  prdata = AMBA_WORD'(ctrl_r);
                ADDR_DATA:  prdata = AMBA_WORD'(data_in_r);
                ADDR_WIDTH: prdata = AMBA_WORD'(width_r);
                ADDR_NOISE: prdata = AMBA_WORD'(noise_r);
                default:    prdata = '0;
            endcase
        end
    end

    assign apb.PRDATA     = prdata;
    assign core_start     = (state == ST_START);
    assign operation_done = (state == ST_DONE);
    assign core_ctrl      = ctrl_r;
    assign core_width     = width_r;
    assign core_data_in   = data_in_r;
    assign core_noise     = noise_r;
    assign data_out       = data_out_r;
    assign num_of_errors  = nerr_r;

endmodule

// File: tb/tb_ecc_apb_regfile.sv
// tb_ecc_apb_regfile
//   Self-checking bench for ecc_apb_regfile: directed scenarios followed by
//   randomized register traffic and operations, checked against a
//   register-map model held in this file. Define ECC_REGFILE_TIMEOUT_EN
//   for both bench and design to exercise the WAIT timeout.
module tb_ecc_apb_regfile;

    logic        clk;
    logic        rst;
    logic        core_start;
    logic [1:0]  core_ctrl;
    logic [1:0]  core_width;
    logic [31:0] core_data_in;
    logic [31:0] core_noise;
    logic        core_done;
    logic [31:0] core_data_out;
    logic [1:0]  core_num_errors;
    logic [31:0] data_out;
    logic        operation_done;
    logic [1:0]  num_of_errors;

    int total = 0;
    int bad   = 0;

    ecc_apb_regfile_if #(.AMBA_ADDR_WIDTH(20), .AMBA_WORD(32)) apb ();

    ecc_apb_regfile #(
        .DATA_WIDTH(32), .AMBA_ADDR_WIDTH(20), .AMBA_WORD(32)
    ) dut (
        .clk(clk), .rst(rst), .apb(apb),
        .core_start(core_start), .core_ctrl(core_ctrl), .core_width(core_width),
        .core_data_in(core_data_in), .core_noise(core_noise),
        .core_done(core_done), .core_data_out(core_data_out),
        .core_num_errors(core_num_errors), .data_out(data_out),
        .operation_done(operation_done), .num_of_errors(num_of_errors)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the four architectural registers by word index.
    logic [31:0] mreg [4];
    logic [31:0] exp_dout;
    logic [1:0]  exp_nerr;

    function automatic logic [31:0] reg_mask(input int idx);
        return (idx == 0 || idx == 2) ? 32'h3 : 32'hFFFF_FFFF;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mreg[i] = '0;
        exp_dout = '0;
        exp_nerr = '0;
    endtask

    task automatic model_write(input logic [19:0] addr, input logic [31:0] d);
        int idx;
        if (addr[1:0] == 2'b00) begin
            idx = int'(addr[3:2]);
            mreg[idx] = d & reg_mask(idx);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [19:0] addr);
        if (addr[1:0] != 2'b00) return 32'h0;
        return mreg[addr[3:2]];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apb_idle();
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    endtask

    task automatic apb_write(input logic [19:0] addr, input logic [31:0] d);
        apb.PADDR = addr; apb.PWDATA = d; apb.PWRITE = 1'b1;
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0;
        step();
        apb.PENABLE = 1'b1;
        step();
        apb_idle();
    endtask

    task automatic apb_read(input logic [19:0] addr, input string tag);
        apb.PADDR = addr; apb.PWRITE = 1'b0; apb.PSEL = 1'b1; apb.PENABLE = 1'b0;
        #1;
        check({tag, "_setup"}, apb.PRDATA, 32'h0);
        step();
        apb.PENABLE = 1'b1;
        #1;
        check(tag, apb.PRDATA, model_read(addr));
        step();
        apb_idle();
    endtask

    task automatic check_core_regs(input string tag);
        check({tag, "_ctrl"},  core_ctrl,    mreg[0][1:0]);
        check({tag, "_din"},   core_data_in, mreg[1]);
        check({tag, "_width"}, core_width,   mreg[2][1:0]);
        check({tag, "_noise"}, core_noise,   mreg[3]);
    endtask

    // Ends in the first WAIT cycle.
    task automatic launch(input logic [31:0] d);
        apb_write(20'h0, d);
        model_write(20'h0, d);
        check("launch_start", core_start, 1'b1);
        check("launch_ctrl", core_ctrl, d[1:0]);
        check("launch_nodone", operation_done, 1'b0);
        step();
        check("wait_nostart", core_start, 1'b0);
    endtask

    // Called in a WAIT cycle; ends in IDLE with the result checked and held.
    task automatic finish(input int delay, input logic [31:0] res, input logic [1:0] ne);
        for (int i = 0; i < delay; i++) begin
            check("wait_nodone", operation_done, 1'b0);
            step();
        end
        check("pre_done", operation_done, 1'b0);
        core_done = 1'b1; core_data_out = res; core_num_errors = ne;
        step();
        core_done = 1'b0; core_data_out = $urandom; core_num_errors = 2'($urandom);
        exp_dout = res; exp_nerr = ne;
        check("done_pulse", operation_done, 1'b1);
        check("done_dout", data_out, exp_dout);
        check("done_nerr", num_of_errors, exp_nerr);
        step();
        check("done_once", operation_done, 1'b0);
        check("hold_dout", data_out, exp_dout);
        check("hold_nerr", num_of_errors, exp_nerr);
    endtask

    logic [19:0] ra;
    logic [31:0] rd;
    logic [31:0] r1;
    logic [31:0] r2;

    initial begin
        rst = 1'b0;
        core_done = 1'b0; core_data_out = '0; core_num_errors = '0;
        apb.PADDR = '0; apb.PWDATA = '0;
        apb_idle();
        model_reset();
        #1;
        check("rst_start", core_start, 1'b0);
        check("rst_done", operation_done, 1'b0);
        check("rst_dout", data_out, 32'h0);
        check("rst_nerr", num_of_errors, 2'b00);
        check("rst_prdata", apb.PRDATA, 32'h0);
        check_core_regs("rst");
        #19 rst = 1'b1;
        step();

        // Basic encode: DATA_IN=0xA5, result 0x1234 one cycle after start.
        apb_write(20'h4, 32'h0000_00A5);
        model_write(20'h4, 32'h0000_00A5);
        check_core_regs("din_wr");
        launch(32'h0);
        finish(0, 32'h0000_1234, 2'b01);

        // Width field keeps two bits; 0x10 aliases CTRL; 0x2 is unmapped.
        apb_write(20'h8, 32'hFFFF_FFFF);
        model_write(20'h8, 32'hFFFF_FFFF);
        apb_read(20'h8, "rd_width");
        apb_read(20'h10, "rd_0x10");
        apb_write(20'h2, 32'hDEAD_BEEF);
        apb_read(20'h2, "rd_unmapped");
        check_core_regs("unmapped_wr");

        // Writes in WAIT are dropped; reads still work.
        apb_write(20'hC, 32'h5555_0000);
        model_write(20'hC, 32'h5555_0000);
        launch(32'h1);
        apb_write(20'hC, 32'h1);
        check("wait_noise", core_noise, 32'h5555_0000);
        apb_read(20'hC, "rd_wait_noise");
        finish(0, 32'hCAFE_0001, 2'b10);

        // CTRL write in DONE relaunches while DONE still pulses.
        r1 = $urandom; r2 = $urandom;
        launch(32'h1);
        core_done = 1'b1; core_data_out = r1; core_num_errors = 2'b01;
        apb.PADDR = 20'h0; apb.PWDATA = 32'h2; apb.PWRITE = 1'b1;
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0;
        step();
        core_done = 1'b0;
        apb.PENABLE = 1'b1;
        check("chain_done", operation_done, 1'b1);
        check("chain_dout1", data_out, r1);
        step();
        apb_idle();
        model_write(20'h0, 32'h2);
        check("chain_start", core_start, 1'b1);
        check("chain_nodone", operation_done, 1'b0);
        check("chain_ctrl", core_ctrl, 2'b10);
        check("chain_hold1", data_out, r1);
        step();
        finish(1, r2, 2'b00);

`ifdef ECC_REGFILE_TIMEOUT_EN
        // No core_done: DONE arrives 9 cycles after START with error code.
        launch(32'h0);
        for (int c = 1; c <= 8; c++) begin
            check("to_wait", operation_done, 1'b0);
            step();
        end
        check("to_done", operation_done, 1'b1);
        check("to_dout", data_out, 32'h0);
        check("to_nerr", num_of_errors, 2'b11);
        exp_dout = '0; exp_nerr = 2'b11;
        step();
        check("to_once", operation_done, 1'b0);
`else
        // No core_done: WAIT holds indefinitely.
        launch(32'h0);
        for (int c = 0; c < 12; c++) begin
            check("nto_wait", operation_done, 1'b0);
            step();
        end
        finish(0, 32'h0BAD_F00D, 2'b11);
`endif

        // Reset in WAIT clears everything at once and loses the operation.
        apb_write(20'h4, 32'h1357_9BDF);
        model_write(20'h4, 32'h1357_9BDF);
        launch(32'h2);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("mrst_dout", data_out, 32'h0);
        check("mrst_nerr", num_of_errors, 2'b00);
        check("mrst_start", core_start, 1'b0);
        check("mrst_done", operation_done, 1'b0);
        check_core_regs("mrst");
        @(negedge clk);
        rst = 1'b1;
        step();
        core_done = 1'b1; core_data_out = 32'hFFFF_FFFF; core_num_errors = 2'b11;
        for (int c = 0; c < 4; c++) begin
            step();
            check("post_rst_done", operation_done, 1'b0);
            check("post_rst_dout", data_out, 32'h0);
        end
        core_done = 1'b0;

        // Randomized register traffic and operations.
        for (int it = 0; it < 24; it++) begin
            ra = 20'($urandom);
            rd = $urandom;
            if (it % 4 == 0) ra[3:0] = 4'h0;
            if (ra[3:0] == 4'h0) begin
                launch(rd);
                finish(int'($urandom_range(0, 4)), $urandom, 2'($urandom));
            end else begin
                apb_write(ra, rd);
                model_write(ra, rd);
            end
            check_core_regs("rnd");
            check("rnd_hold", data_out, exp_dout);
            ra = 20'($urandom);
            if (it % 3 == 0) ra[1:0] = 2'b00;
            apb_read(ra, "rnd_rd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
